// File: rtl/stream_max_pkg.sv
// Shared definitions for the streaming signed extreme-value finder.
//   state_t  : frame controller states (ACCUM collects samples, HOLD offers
//              the frame result downstream)
//   MODE_MAX : select the largest sample of a frame
//   MODE_MIN : select the smallest sample of a frame
package stream_max_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int MODE_MAX = 0;
  localparam int MODE_MIN = 1;

endpackage

// File: rtl/sint_better.sv
// Strict signed comparator: reports whether a candidate sample beats the
// current best under the selected ordering. Purely combinational.
//   cand   : candidate sample (signed)
//   best   : current best sample (signed)
//   better : 1 when cand > best (MODE_MAX) or cand < best (MODE_MIN);
//            equal values never count as better
module sint_better
  import stream_max_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MODE  = MODE_MAX
) (
  input  logic signed [WIDTH-1:0] cand,
  input  logic signed [WIDTH-1:0] best,
  output logic                    better
);

  always_comb begin
    if (MODE == MODE_MIN) better = (cand < best);
    else                  better = (cand > best);
  end

endmodule

// File: rtl/stream_max_sint.sv
// Streaming frame extreme-value finder for signed samples. Samples arrive on a
// valid/ready input stream, a frame ends with in_last, and one result per frame
// (extreme value, its position, frame length and overflow flag) is offered on a
// valid/ready output until it is taken.
//   clk, rst               : clock, asynchronous active-high reset
//   in_valid/in_ready      : input handshake
//   in_data, in_last       : signed sample and end-of-frame marker
//   out_valid/out_ready    : result handshake
//   out_data               : extreme value of the frame
//   out_idx                : 0-based position of out_data (first occurrence)
//   out_count              : samples in frame minus 1 (saturating)
//   out_ovf                : frame held more than 2**IDX_W samples
module stream_max_sint
  import stream_max_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = 8,
  parameter int MODE  = MODE_MAX
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic [IDX_W-1:0]        out_count,
  output logic                    out_ovf
);

  localparam logic [IDX_W-1:0] IDX_MAX = '1;
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  state_t                  state, state_nxt;
  logic                    rdy_en;
  logic                    started;
  logic signed [WIDTH-1:0] best;
  logic [IDX_W-1:0]        best_idx;
  logic [IDX_W-1:0]        pos;
  logic                    ovf;

  logic                    accept;
  logic                    cand_better;
  logic                    pos_sat;
  logic [IDX_W-1:0]        cand_idx;
  logic signed [WIDTH-1:0] best_nxt;
  logic [IDX_W-1:0]        best_idx_nxt;
  logic [IDX_W-1:0]        pos_nxt;
  logic                    ovf_nxt;

  // rdy_en keeps in_ready low while rst is high and until the first clock
  // edge after release, independent of the state encoding.
  assign in_ready  = rdy_en && (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign pos_sat   = (pos == IDX_MAX);

  sint_better #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_better (
    .cand   (in_data),
    .best   (best),
    .better (cand_better)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && in_last) state_nxt = HOLD;
      HOLD:    if (out_ready)         state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Frame accumulator update for the sample currently offered. Once the
  // position counter saturates it stops, later samples take the saturated
  // index and mark the frame as overflowed.
  always_comb begin
    best_nxt     = best;
    best_idx_nxt = best_idx;
    pos_nxt      = pos;
    ovf_nxt      = ovf;
    cand_idx     = pos_sat ? pos : (pos + IDX_ONE);
    if (!started) begin
      best_nxt     = in_data;
      best_idx_nxt = '0;
      pos_nxt      = '0;
      ovf_nxt      = 1'b0;
    end else begin
      pos_nxt = cand_idx;
      if (pos_sat) ovf_nxt = 1'b1;
      if (cand_better) begin
        best_nxt     = in_data;
        best_idx_nxt = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      rdy_en    <= 1'b0;
      started   <= 1'b0;
      best      <= '0;
      best_idx  <= '0;
      pos       <= '0;
      ovf       <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
      if (accept) begin
        if (in_last) begin
          // Result is latched into the output registers and the frame state
          // is cleared now; nothing is accepted in HOLD, so the next frame
          // starts clean after the result handshake.
          out_data  <= best_nxt;
          out_idx   <= best_idx_nxt;
          out_count <= pos_nxt;
          out_ovf   <= ovf_nxt;
          started   <= 1'b0;
          best      <= '0;
          best_idx  <= '0;
          pos       <= '0;
          ovf       <= 1'b0;
        end else begin
          started  <= 1'b1;
          best     <= best_nxt;
          best_idx <= best_idx_nxt;
          pos      <= pos_nxt;
          ovf      <= ovf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_max_sint.sv
// Directed and randomised bench for stream_max_sint. Three instances share the
// input and out_ready signals: max/IDX_W=8, min/IDX_W=8 and max/IDX_W=2.
module tb_stream_max_sint;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;

  logic in_ready0, in_ready1, in_ready2;
  logic out_valid0, out_valid1, out_valid2;
  logic signed [15:0] out_data0, out_data1, out_data2;
  logic [7:0] out_idx0, out_idx1, out_count0, out_count1;
  logic [1:0] out_idx2, out_count2;
  logic out_ovf0, out_ovf1, out_ovf2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_max_sint #(.WIDTH(16), .IDX_W(8), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_idx(out_idx0),
    .out_count(out_count0), .out_ovf(out_ovf0));

  stream_max_sint #(.WIDTH(16), .IDX_W(8), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_idx(out_idx1),
    .out_count(out_count1), .out_ovf(out_ovf1));

  stream_max_sint #(.WIDTH(16), .IDX_W(2), .MODE(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_idx(out_idx2),
    .out_count(out_count2), .out_ovf(out_ovf2));

  typedef struct {
    int               len;
    logic [7:0][15:0] s;
    int mx, mx_idx, cnt;
    int mn, mn_idx;
    int x2, x2_idx, x2_cnt, x2_ovf;
  } vec_t;

  typedef struct {
    int d0, i0, c0, o0;
    int d1, i1, c1, o1;
    int d2, i2, c2, o2;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic vec_t mkv(input int len, input int a0, input int a1,
                               input int a2, input int a3, input int a4,
                               input int a5, input int mx, input int mxi,
                               input int cnt, input int mn, input int mni,
                               input int x2, input int x2i, input int x2c,
                               input int x2o);
    vec_t v;
    v.len = len;
    v.s = '0;
    v.s[0] = a0[15:0]; v.s[1] = a1[15:0]; v.s[2] = a2[15:0];
    v.s[3] = a3[15:0]; v.s[4] = a4[15:0]; v.s[5] = a5[15:0];
    v.mx = mx; v.mx_idx = mxi; v.cnt = cnt;
    v.mn = mn; v.mn_idx = mni;
    v.x2 = x2; v.x2_idx = x2i; v.x2_cnt = x2c; v.x2_ovf = x2o;
    return v;
  endfunction

  // Reference behaviour of one instance for a whole frame.
  function automatic void model(input int mode, input int idxw, input int len,
                                input logic [7:0][15:0] s, output int d,
                                output int idx, output int cnt, output int ovf);
    int maxi = (1 << idxw) - 1;
    int v;
    d = 0; idx = 0;
    for (int i = 0; i < len; i++) begin
      v = int'($signed(s[i]));
      if (i == 0) begin
        d = v; idx = 0;
      end else if ((mode == 0) ? (v > d) : (v < d)) begin
        d = v; idx = (i > maxi) ? maxi : i;
      end
    end
    cnt = ((len - 1) > maxi) ? maxi : (len - 1);
    ovf = (len > maxi + 1) ? 1 : 0;
  endfunction

  // Offer one sample from the negedge until accepted (bounded).
  task automatic put(input logic [15:0] d, input logic last);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    while (!in_ready0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("accept_timeout", 0, 1);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", n);
    out_ready = 1'b0;
    for (int i = 0; i < v.len; i++) begin
      put(v.s[i], (i == v.len - 1));
      if (i == v.len - 1) chk({tag, "_valid_before_last"}, int'(out_valid0), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    chk({tag, "_latency_valid"}, int'(out_valid0), 1);
    chk({tag, "_hold_ready"}, int'(in_ready0), 0);
    chk({tag, "_max_data"}, int'(out_data0), v.mx);
    chk({tag, "_max_idx"}, int'(out_idx0), v.mx_idx);
    chk({tag, "_max_cnt"}, int'(out_count0), v.cnt);
    chk({tag, "_max_ovf"}, int'(out_ovf0), 0);
    chk({tag, "_min_data"}, int'(out_data1), v.mn);
    chk({tag, "_min_idx"}, int'(out_idx1), v.mn_idx);
    chk({tag, "_min_cnt"}, int'(out_count1), v.cnt);
    chk({tag, "_x2_data"}, int'(out_data2), v.x2);
    chk({tag, "_x2_idx"}, int'(out_idx2), v.x2_idx);
    chk({tag, "_x2_cnt"}, int'(out_count2), v.x2_cnt);
    chk({tag, "_x2_ovf"}, int'(out_ovf2), v.x2_ovf);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_after_hs_valid"}, int'(out_valid0), 0);
    chk({tag, "_after_hs_ready"}, int'(in_ready0), 1);
  endtask

  vec_t vt [6];

  initial begin
    // len, samples, max/idx/cnt, min/idx, x2 data/idx/cnt/ovf
    vt[0] = mkv(5, 5, -3, 7, -32768, 7, 0,      7, 2, 4,  -32768, 3,  7, 2, 3, 1);
    vt[1] = mkv(3, -1, 32767, -32768, 0, 0, 0,  32767, 1, 2,  -32768, 2,  32767, 1, 2, 0);
    vt[2] = mkv(2, -1, 0, 0, 0, 0, 0,           0, 1, 1,  -1, 0,  0, 1, 1, 0);
    vt[3] = mkv(6, 1, 2, 3, 4, 9, 5,            9, 4, 5,  1, 0,  9, 3, 3, 1);
    vt[4] = mkv(1, -32768, 0, 0, 0, 0, 0,       -32768, 0, 0,  -32768, 0,  -32768, 0, 0, 0);
    vt[5] = mkv(3, 3, 3, 3, 0, 0, 0,            3, 0, 2,  3, 0,  3, 0, 2, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready0), 0);
    chk("rst_out_valid", int'(out_valid0), 0);
    chk("rst_out_data", int'(out_data0), 0);
    chk("rst_out_idx", int'(out_idx0), 0);
    chk("rst_out_count", int'(out_count0), 0);
    chk("rst_out_ovf", int'(out_ovf0), 0);
    rst = 1'b0;
    chk("rst_release_ready", int'(in_ready0), 0);
    @(negedge clk);
    chk("post_rst_ready", int'(in_ready0), 1);

    for (int n = 0; n < 6; n++) run_vec(n, vt[n]);

    // Result held under back-pressure for 10 cycles
    put(16'h8000, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("hold_stable",
          int'(out_valid0 && !in_ready0 && out_data0 == -16'sd32768 &&
               out_idx0 == 8'd0 && out_count0 == 8'd0 && !out_ovf0), 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_release_valid", int'(out_valid0), 0);
    chk("hold_release_ready", int'(in_ready0), 1);

    // Reset in the middle of a frame
    put(16'd100, 1'b0);
    put(16'd200, 1'b0);
    put(16'd300, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_valid", int'(out_valid0), 0);
    chk("midrst_ready", int'(in_ready0), 0);
    chk("midrst_data_clr", int'(out_data0), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_no_result", int'(out_valid0), 0);
    end
    put(16'd4, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("midrst_valid_new", int'(out_valid0), 1);
    chk("midrst_data_new", int'(out_data0), 4);
    chk("midrst_idx_new", int'(out_idx0), 0);
    chk("midrst_cnt_new", int'(out_count0), 0);
    out_ready = 1'b1;
    @(negedge clk);

    // Randomised back-pressure over 1000 frames
    begin
      int got = 0;
      fork
        begin
          for (int f = 0; f < 1000; f++) begin
            int len;
            logic [7:0][15:0] s;
            exp_t e;
            len = $urandom_range(1, 6);
            s = '0;
            for (int i = 0; i < len; i++) begin
              if ($urandom_range(0, 3) == 0) s[i] = 16'($urandom_range(0, 3)) - 16'd1;
              else s[i] = 16'($urandom);
            end
            model(0, 8, len, s, e.d0, e.i0, e.c0, e.o0);
            model(1, 8, len, s, e.d1, e.i1, e.c1, e.o1);
            model(0, 2, len, s, e.d2, e.i2, e.c2, e.o2);
            exp_q.push_back(e);
            for (int i = 0; i < len; i++) begin
              if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
              end
              put(s[i], (i == len - 1));
            end
          end
          @(negedge clk);
          in_valid = 1'b0;
          in_last = 1'b0;
        end
        begin
          int cyc = 0;
          while (got < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 1) == 1);
            if (out_valid0 && out_ready) begin
              exp_t e;
              if (exp_q.size() == 0) begin
                chk("rand_unexpected_result", 1, 0);
              end else begin
                e = exp_q.pop_front();
                checks++;
                if (!(out_valid1 && out_valid2 && in_ready1 == in_ready0 &&
                      in_ready2 == in_ready0 &&
                      int'(out_data0) == e.d0 && int'(out_idx0) == e.i0 &&
                      int'(out_count0) == e.c0 && int'(out_ovf0) == e.o0 &&
                      int'(out_data1) == e.d1 && int'(out_idx1) == e.i1 &&
                      int'(out_count1) == e.c1 && int'(out_ovf1) == e.o1 &&
                      int'(out_data2) == e.d2 && int'(out_idx2) == e.i2 &&
                      int'(out_count2) == e.c2 && int'(out_ovf2) == e.o2)) begin
                  failures++;
                  $display("FAIL rand_frame%0d: got max %0d/%0d/%0d/%0d min %0d/%0d/%0d/%0d x2 %0d/%0d/%0d/%0d, expected max %0d/%0d/%0d/%0d min %0d/%0d/%0d/%0d x2 %0d/%0d/%0d/%0d",
                           got, out_data0, out_idx0, out_count0, out_ovf0,
                           out_data1, out_idx1, out_count1, out_ovf1,
                           out_data2, out_idx2, out_count2, out_ovf2,
                           e.d0, e.i0, e.c0, e.o0, e.d1, e.i1, e.c1, e.o1,
                           e.d2, e.i2, e.c2, e.o2);
                end
              end
              got++;
            end
          end
          out_ready = 1'b0;
        end
      join
      chk("rand_result_count", got, 1000);
      chk("rand_leftover", exp_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_max_sint.md
STREAM_MAX_SINT -- requirements
Module: stream_max_sint

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the signed sample width in bits.
REQ-002 The module SHALL have parameter IDX_W, default 8, giving the sample-index and count width.
REQ-003 The module SHALL have parameter MODE, default 0, where 0 selects maximum and 1 selects minimum.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port in_valid, input, 1 bit: in_data and in_last are valid.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the block can accept a sample.
REQ-008 The module SHALL have port in_data, input, WIDTH bits: signed two's-complement sample.
REQ-009 The module SHALL have port in_last, input, 1 bit: this sample is the final sample of its frame.
REQ-010 The module SHALL have port out_valid, output, 1 bit: the frame result is valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The module SHALL have port out_data, output, WIDTH bits, signed: the extreme value of the frame.
REQ-013 The module SHALL have port out_idx, output, IDX_W bits: the 0-based frame position of out_data.
REQ-014 The module SHALL have port out_count, output, IDX_W bits: the number of samples in the frame, minus 1.
REQ-015 The module SHALL have port out_ovf, output, 1 bit: the frame exceeded 2**IDX_W samples.

Function
REQ-016 A sample SHALL be accepted only on a clock edge where in_valid and in_ready are both 1.
REQ-017 The block SHALL use two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-018 In ACCUM, the first accepted sample of a frame SHALL load the best register unconditionally, with best index 0.
REQ-019 Each later sample SHALL replace the best value only when it compares strictly better (MODE 0: greater, MODE 1: less) under signed comparison.
REQ-020 On equal values, the earliest index SHALL be retained.
REQ-021 The position counter SHALL increment per accepted sample and saturate at 2**IDX_W-1.
REQ-022 An accepted sample arriving while the counter is already saturated SHALL set a sticky overflow flag for the frame.
REQ-023 Indices of samples accepted after saturation SHALL be recorded as 2**IDX_W-1.
REQ-024 Acceptance of a sample with in_last=1 SHALL include that sample in the frame and move ACCUM to HOLD.
REQ-025 out_valid SHALL be 1 on the cycle after the final sample is accepted (latency 1).
REQ-026 In HOLD, out_data, out_idx, out_count and out_ovf SHALL remain stable until out_valid and out_ready are both 1.
REQ-027 A result handshake SHALL return the block to ACCUM with the frame state cleared.
REQ-028 A new sample SHALL be accepted no earlier than the cycle after the handshake; there is no input/output bypass.
REQ-029 A single-sample frame (in_last on the first sample) SHALL yield out_idx=0 and out_count=0.
REQ-030 in_ready SHALL depend only on state, never combinationally on out_ready.
REQ-031 Outputs SHALL hold their last values while in ACCUM, but are meaningful only while out_valid=1.

Reset
REQ-032 While rst=1, the block SHALL immediately enter ACCUM with out_valid=0, and out_data, out_idx, out_count and out_ovf all 0.
REQ-033 Reset in the middle of a frame or during HOLD SHALL discard the partial frame or pending result without emitting it.
REQ-034 While rst=1, in_ready SHALL be 0; it SHALL become 1 on the first clock edge after rst deasserts.

Structure
REQ-035 Shared package stream_max_pkg SHALL hold the state enum (ACCUM, HOLD) and the MODE_MAX=0 and MODE_MIN=1 constants.
REQ-036 Sub-module sint_better SHALL be a combinational, WIDTH- and MODE-parametrised signed strict comparator; it SHALL be the only place comparison is done.
REQ-037 All registers SHALL reside in stream_max_sint, in one async-reset sequential process.

Verification
REQ-038 WIDTH=16, MODE=0, frame 5, -3, 7, -32768, 7(last), out_ready=1 -> out_data=7, out_idx=2, out_count=4, out_ovf=0, out_valid 1 cycle after last.
REQ-039 MODE=1, frame -1, 32767, -32768(last) -> out_data=-32768, out_idx=2; also check -1 vs 0 under signed (not unsigned) ordering.
REQ-040 Single sample 0x8000 with in_last, out_ready held 0 for 10 cycles -> out_valid stays 1, in_ready=0, outputs stable; then out_ready=1 -> ACCUM next cycle.
REQ-041 IDX_W=2, frame of 6 samples 1,2,3,4,9,5(last) -> out_count=3, out_ovf=1, out_data=9, out_idx=3.
REQ-042 rst asserted after 3 samples mid-frame, then frame 4(last) -> result out_data=4, out_idx=0; no result emitted for the aborted frame.
REQ-043 Randomised in_valid/out_ready back-pressure over 1000 frames -> every result matches a reference model; no sample is lost or duplicated.
